countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counting interval timer with a valid/ready expiry handshake. It paces generation steps of the Conway simulation: the controller programs a period in ticks, starts the timer, and consumes one expiry event per elapsed period. It is the down-counting counterpart of the free-running up-counter. It raises events toward a consumer instead of only wrapping locally.

## Interface
- `WIDTH`, 8: width of period and count.
- `DEFAULT_PERIOD`, 100: period register value after reset; must be nonzero.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `enable` in 1: tick qualifier; the count advances only on cycles with `enable`=1.
- `load` in 1: write `load_value` to the period register.
- `load_value` in WIDTH: new period.
- `start` in 1: arm or restart the timer.
- `stop` in 1: abort the timer.
- `periodic` in 1: sampled at expiry; 1 = auto-reload, 0 = one-shot.
- `count` out WIDTH: remaining ticks (registered).
- `busy` out 1: 1 while in RUN.
- `done_valid` out 1: expiry event pending.
- `done_ready` in 1: consumer accepts the event.
- `overrun` out 1: sticky; an expiry occurred while `done_valid` was already pending and not accepted.
- `miss_count` out 8: only with `COUNTDOWN_TIMER_MISS_CNT_EN`.

## Operation
- Reset values:
  - `count`=0, period=`DEFAULT_PERIOD`, state IDLE, `busy`=0.
  - `done_valid`=0, `overrun`=0, `miss_count`=0.
- States are IDLE and RUN. `busy` is the registered value of (state==RUN).
- `load`: period<=`load_value` in any state. In RUN it does not affect `count`; it takes effect at the next reload or start.
- `load` with `load_value`=0 is ignored; the period stays unchanged.
- `start` (with `stop`=0):
  - count<=period and state<=RUN.
  - If `load` is asserted the same cycle, the new `load_value` is used.
  - `start` in RUN restarts: count reloads and no expiry is generated.
- `stop`: state<=IDLE, count<=0, no expiry. `stop` has priority over `start`, `enable`, and a concurrent expiry.
- RUN with `enable`=1 and no `start`/`stop`:
  - If `count`==1, this is an expiry tick:
    - `periodic`=1: count<=period, stay in RUN.
    - `periodic`=0: count<=0, go to IDLE.
  - Otherwise count<=count-1.
- RUN with `enable`=0: hold.
- IDLE ignores `enable`.
- Expiry handshake:
  - An expiry tick sets `done_valid` on the next edge.
  - `done_valid` stays high until a cycle with `done_valid` and `done_ready` both 1; it clears on that edge.
  - If an expiry coincides with an accepting cycle, `done_valid` stays 1 (new event, no overrun).
  - If an expiry occurs while `done_valid`=1 and `done_ready`=0, `overrun`<=1 and `done_valid` stays 1. Events are not queued.
  - `overrun` clears only on an accepting handshake cycle with no concurrent overrun.
  - `done_ready` with `done_valid`=0 has no effect.
- Arithmetic: unsigned WIDTH-bit. The maximum period is 2^WIDTH-1. `count` never wraps below 0.

## Timing
- Start at edge N: `count`=period and `busy`=1 visible after edge N.
- With `enable` held high, the expiry tick occurs at edge N+period, and `done_valid` rises after that edge.
- Periodic mode: expiries are exactly `period` enabled ticks apart, with no dead cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Asserting `resetn` low mid-operation forces all reset values immediately (asynchronously). Deassertion is synchronized externally.

## Configuration
- `COUNTDOWN_TIMER_MISS_CNT_EN` defined:
  - Adds the `miss_count` output, 8 bits, saturating at 255.
  - Increments on every expiry that sets or keeps `overrun`.
  - Clears to 0 together with `overrun` on an accepting handshake.
  - If a miss coincides with the accepting cycle, it is loaded with 1.
- Undefined: the `miss_count` port and its logic are absent; `overrun` behaviour is unchanged.

## Test plan
- Reset, then `load_value`=5, `start`, `enable`=1, `periodic`=0, `done_ready`=0 -> `count` steps 5,4,3,2,1,0; `done_valid` rises 5 edges after start; `busy` falls together with it.
- `periodic`=1, period 3, `done_ready`=1 continuously -> `done_valid` pulses one cycle every 3 cycles; `overrun` stays 0.
- `periodic`=1, period 2, `done_ready`=0 for 7 cycles -> `done_valid` stuck at 1, `overrun`=1; with the macro, `miss_count`=2. One accepting cycle then clears all three.
- `stop` asserted on the expiry tick (`count`=1, `enable`=1) -> IDLE, `count`=0, `done_valid` stays 0.
- `enable` toggling 1,0,1,0 with period 2 -> expiry occurs after the 2nd enabled cycle, not the 2nd clock.
- `resetn` pulsed low mid-RUN with `done_valid`=1 and `overrun`=1 -> all outputs return to reset values immediately; period reverts to 100.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable down-counting interval timer with a valid/ready expiry handshake.
// Optional miss counter enabled by defining COUNTDOWN_TIMER_MISS_CNT_EN.
module countdown_timer #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DEFAULT_PERIOD = 100
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             overrun
`ifdef COUNTDOWN_TIMER_MISS_CNT_EN
  ,
  output logic [7:0]       miss_count
`endif
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] period, period_next;
  logic [WIDTH-1:0] count_next;
  logic             expire;
  logic             accept;
  logic             miss;
  logic             done_valid_next;
  logic             overrun_next;

  always_comb begin
    // A zero load is dropped so the period can never become zero.
    period_next = (load && (load_value != '0)) ? load_value : period;
    state_next  = state;
    count_next  = count;
    expire      = 1'b0;
    if (stop) begin
      state_next = IDLE;
      count_next = '0;
    end else if (start) begin
      state_next = RUN;
      count_next = period_next;
    end else if ((state == RUN) && enable) begin
      if (count == WIDTH'(1)) begin
        expire = 1'b1;
        if (periodic) begin
          count_next = period;
        end else begin
          count_next = '0;
          state_next = IDLE;
        end
      end else if (count != '0) begin
        count_next = count - WIDTH'(1);
      end
    end
  end

  always_comb begin
    accept          = done_valid && done_ready;
    miss            = expire && done_valid && !done_ready;
    done_valid_next = done_valid;
    overrun_next    = overrun;
    if (expire) begin
      done_valid_next = 1'b1;
    end else if (accept) begin
      done_valid_next = 1'b0;
    end
    if (miss) begin
      overrun_next = 1'b1;
    end else if (accept) begin
      overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      period     <= WIDTH'(DEFAULT_PERIOD);
      count      <= '0;
      busy       <= 1'b0;
      done_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      period     <= period_next;
      count      <= count_next;
      busy       <= (state_next == RUN);
      done_valid <= done_valid_next;
      overrun    <= overrun_next;
    end
  end

`ifdef COUNTDOWN_TIMER_MISS_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      miss_count <= '0;
    end else if (miss) begin
      miss_count <= (miss_count == '1) ? miss_count : miss_count + 8'd1;
    end else if (accept) begin
      miss_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues expected outputs per
// cycle, a monitor pops and compares them on the falling edge.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       periodic = 1'b0;
  logic       done_ready = 1'b0;
  logic [7:0] count;
  logic       busy;
  logic       done_valid;
  logic       overrun;
`ifdef COUNTDOWN_TIMER_MISS_CNT_EN
  logic [7:0] miss_count;
`endif

  countdown_timer #(
    .WIDTH(8),
    .DEFAULT_PERIOD(100)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .load(load),
    .load_value(load_value),
    .start(start),
    .stop(stop),
    .periodic(periodic),
    .count(count),
    .busy(busy),
    .done_valid(done_valid),
    .done_ready(done_ready),
    .overrun(overrun)
`ifdef COUNTDOWN_TIMER_MISS_CNT_EN
    ,
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] c;
    logic       b;
    logic       dv;
    logic       ov;
    logic [7:0] mc;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  event sample_ev;

  task automatic chk(input string name, input string field,
                     input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%0d required=%0d", name, field, act, req);
    end
  endtask

  always @(negedge clk or sample_ev) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, "count", count, e.c);
      chk(e.name, "busy", {7'd0, busy}, {7'd0, e.b});
      chk(e.name, "done_valid", {7'd0, done_valid}, {7'd0, e.dv});
      chk(e.name, "overrun", {7'd0, overrun}, {7'd0, e.ov});
`ifdef COUNTDOWN_TIMER_MISS_CNT_EN
      chk(e.name, "miss_count", miss_count, e.mc);
`endif
    end
  end

  task automatic push(input logic [7:0] ec, input logic eb, input logic edv,
                      input logic eov, input logic [7:0] emc, input string name);
    exp_t e;
    e.c = ec; e.b = eb; e.dv = edv; e.ov = eov; e.mc = emc; e.name = name;
    q.push_back(e);
  endtask

  // One clock: drive inputs, expect outputs after the rising edge.
  task automatic cyc(input logic en, input logic ld, input logic [7:0] lv,
                     input logic st, input logic sp, input logic per, input logic rdy,
                     input logic [7:0] ec, input logic eb, input logic edv,
                     input logic eov, input logic [7:0] emc, input string name);
    enable = en; load = ld; load_value = lv; start = st; stop = sp;
    periodic = per; done_ready = rdy;
    @(posedge clk);
    push(ec, eb, edv, eov, emc, name);
    @(negedge clk);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic async_reset(input string name);
    enable = 0; load = 0; start = 0; stop = 0; done_ready = 0;
    #2 resetn = 1'b0;
    #1 push(8'd0, 1'b0, 1'b0, 1'b0, 8'd0, name);
    ->sample_ev;
    @(negedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    async_reset("reset");
    cyc(0,0,0,0,0,0,0, 0,0,0,0,0, "idle");
    // one-shot period 5
    cyc(1,1,5,1,0,0,0, 5,1,0,0,0, "os_start");
    cyc(1,0,0,0,0,0,0, 4,1,0,0,0, "os_c4");
    cyc(1,0,0,0,0,0,0, 3,1,0,0,0, "os_c3");
    cyc(1,0,0,0,0,0,0, 2,1,0,0,0, "os_c2");
    cyc(1,0,0,0,0,0,0, 1,1,0,0,0, "os_c1");
    cyc(1,0,0,0,0,0,0, 0,0,1,0,0, "os_expire");
    cyc(1,0,0,0,0,0,0, 0,0,1,0,0, "os_hold");
    cyc(0,0,0,0,0,0,1, 0,0,0,0,0, "os_accept");
    cyc(0,0,0,0,0,0,1, 0,0,0,0,0, "os_ready_idle");
    // periodic period 3, always ready
    cyc(1,1,3,1,0,1,1, 3,1,0,0,0, "p3_start");
    cyc(1,0,0,0,0,1,1, 2,1,0,0,0, "p3_a2");
    cyc(1,0,0,0,0,1,1, 1,1,0,0,0, "p3_a1");
    cyc(1,0,0,0,0,1,1, 3,1,1,0,0, "p3_exp1");
    cyc(1,0,0,0,0,1,1, 2,1,0,0,0, "p3_b2");
    cyc(1,0,0,0,0,1,1, 1,1,0,0,0, "p3_b1");
    cyc(1,0,0,0,0,1,1, 3,1,1,0,0, "p3_exp2");
    cyc(1,0,0,0,0,1,1, 2,1,0,0,0, "p3_c2");
    cyc(1,0,0,0,1,1,1, 0,0,0,0,0, "p3_stop");
    // period 1: expiry coinciding with accept keeps done_valid, no overrun
    cyc(1,1,1,1,0,1,1, 1,1,0,0,0, "p1_start");
    cyc(1,0,0,0,0,1,1, 1,1,1,0,0, "p1_exp");
    cyc(1,0,0,0,0,1,1, 1,1,1,0,0, "p1_accept_exp");
    cyc(1,0,0,0,1,1,1, 0,0,0,0,0, "p1_stop");
    // periodic period 2, consumer stalled -> overrun
    cyc(1,1,2,1,0,1,0, 2,1,0,0,0, "ov_start");
    cyc(1,0,0,0,0,1,0, 1,1,0,0,0, "ov_1");
    cyc(1,0,0,0,0,1,0, 2,1,1,0,0, "ov_exp1");
    cyc(1,0,0,0,0,1,0, 1,1,1,0,0, "ov_3");
    cyc(1,0,0,0,0,1,0, 2,1,1,1,1, "ov_miss1");
    cyc(1,0,0,0,0,1,0, 1,1,1,1,1, "ov_5");
    cyc(1,0,0,0,0,1,0, 2,1,1,1,2, "ov_miss2");
    cyc(0,0,0,0,0,1,1, 2,1,0,0,0, "ov_accept");
    cyc(0,0,0,0,1,1,0, 0,0,0,0,0, "ov_stop");
    // restart in RUN, then stop on the expiry tick
    cyc(1,1,3,1,0,0,0, 3,1,0,0,0, "rs_start");
    cyc(1,0,0,0,0,0,0, 2,1,0,0,0, "rs_2");
    cyc(1,0,0,0,0,0,0, 1,1,0,0,0, "rs_1");
    cyc(1,0,0,1,0,0,0, 3,1,0,0,0, "rs_restart");
    cyc(1,0,0,0,0,0,0, 2,1,0,0,0, "rs_r2");
    cyc(1,0,0,0,0,0,0, 1,1,0,0,0, "rs_r1");
    cyc(1,0,0,0,1,0,0, 0,0,0,0,0, "rs_stop_tick");
    cyc(1,0,0,0,0,0,0, 0,0,0,0,0, "rs_idle");
    // enable toggling, period 2
    cyc(1,1,2,1,0,0,0, 2,1,0,0,0, "en_start");
    cyc(1,0,0,0,0,0,0, 1,1,0,0,0, "en_on1");
    cyc(0,0,0,0,0,0,0, 1,1,0,0,0, "en_off1");
    cyc(1,0,0,0,0,0,0, 0,0,1,0,0, "en_on2");
    cyc(0,0,0,0,0,0,0, 0,0,1,0,0, "en_off2");
    cyc(0,0,0,0,0,0,1, 0,0,0,0,0, "en_accept");
    // zero load ignored; load during RUN applies at reload
    cyc(0,1,0,0,0,0,0, 0,0,0,0,0, "ld_zero");
    cyc(1,0,0,1,0,1,0, 2,1,0,0,0, "ld_start");
    cyc(0,1,9,0,0,1,0, 2,1,0,0,0, "ld_run");
    cyc(1,0,0,0,0,1,0, 1,1,0,0,0, "ld_1");
    cyc(1,0,0,0,0,1,0, 9,1,1,0,0, "ld_reload");
    cyc(0,0,0,0,1,1,1, 0,0,0,0,0, "ld_stop");
    // maximum period
    cyc(1,1,255,1,0,0,0, 255,1,0,0,0, "max_start");
    cyc(1,0,0,0,0,0,0, 254,1,0,0,0, "max_254");
    cyc(0,0,0,0,1,0,0, 0,0,0,0,0, "max_stop");
    // async reset mid-RUN with done_valid and overrun set
    cyc(1,1,2,1,0,1,0, 2,1,0,0,0, "rr_start");
    cyc(1,0,0,0,0,1,0, 1,1,0,0,0, "rr_1");
    cyc(1,0,0,0,0,1,0, 2,1,1,0,0, "rr_exp");
    cyc(1,0,0,0,0,1,0, 1,1,1,0,0, "rr_3");
    cyc(1,0,0,0,0,1,0, 2,1,1,1,1, "rr_miss");
    async_reset("rr_reset");
    cyc(0,0,0,0,0,0,0, 0,0,0,0,0, "rr_idle");
    cyc(1,0,0,1,0,0,0, 100,1,0,0,0, "rr_default_period");
    cyc(1,0,0,0,0,0,0, 99,1,0,0,0, "rr_99");
    cyc(0,0,0,0,1,0,0, 0,0,0,0,0, "rr_stop");
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
